// File: rtl/moore_pattern_det.sv
// Moore-style serial pattern detector.
// Tracks how many leading bits of PATTERN the incoming stream currently
// matches, raises a registered match flag while the full pattern has just
// been seen, and keeps a saturating count of detections.
module moore_pattern_det #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8,
   localparam int              LVL_W   = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             clr,
   output logic             match,
   output logic [LVL_W-1:0] level,
   output logic [CNT_W-1:0] match_cnt
);

   // The FSM state is a phase plus the number of pattern bits matched so
   // far. PART with level k is the state Pk; DET always carries level PAT_W.
   // The level register doubles as the level output.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PART = 2'd1,
      DET  = 2'd2
   } PhaseState;

   // Length of the longest pattern prefix that is a suffix of the string
   // made of the first k pattern bits followed by bit b. A result of k+1
   // means b extended the match; anything shorter is the fallback point.
   function automatic int stepLen(input int k, input logic b);
      logic [16:0] seqBits;
      logic        same;
      seqBits = '0;
      for (int i = 0; i < k; i++) begin
         seqBits[i] = PATTERN[PAT_W-1-i];
      end
      seqBits[k] = b;
      for (int j = k + 1; j > 0; j--) begin
         same = 1'b1;
         for (int i = 0; i < j; i++) begin
            if (seqBits[k+1-j+i] != PATTERN[PAT_W-1-i]) begin
               same = 1'b0;
            end
         end
         if (same) begin
            return j;
         end
      end
      return 0;
   endfunction

   // Length of the longest proper prefix of PATTERN that is also a suffix
   // of it; this is where an overlapping search resumes after a detection.
   function automatic int borderLen();
      logic same;
      for (int j = PAT_W - 1; j > 0; j--) begin
         same = 1'b1;
         for (int i = 0; i < j; i++) begin
            if (PATTERN[PAT_W-1-i] != PATTERN[j-1-i]) begin
               same = 1'b0;
            end
         end
         if (same) begin
            return j;
         end
      end
      return 0;
   endfunction

   localparam int               F_LEN       = OVERLAP ? borderLen() : 0;
   localparam int               TBL_N       = 2 ** LVL_W;
   localparam logic [LVL_W-1:0] FULL_LVL    = LVL_W'(PAT_W);
   localparam logic [LVL_W-1:0] RESTART_LVL = LVL_W'(F_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   PhaseState        phase;
   logic [LVL_W-1:0] nextOnZero [TBL_N];
   logic [LVL_W-1:0] nextOnOne  [TBL_N];
   logic [LVL_W-1:0] fromLvl;
   logic [LVL_W-1:0] stepLvl;
   logic             legalSrc;
   logic             enterDet;

   // The transition table is fixed by PATTERN, so every entry is folded to
   // a constant while the design is elaborated. Entries past PAT_W-1 can
   // only be reached from a corrupted level and simply point back to 0;
   // sizing the table to a power of two keeps the lookup index full width.
   for (genvar k = 0; k < TBL_N; k++) begin : gTable
      if (k < PAT_W) begin : gLegal
         localparam logic [LVL_W-1:0] ZERO_NEXT = LVL_W'(stepLen(k, 1'b0));
         localparam logic [LVL_W-1:0] ONE_NEXT  = LVL_W'(stepLen(k, 1'b1));
         assign nextOnZero[k] = ZERO_NEXT;
         assign nextOnOne[k]  = ONE_NEXT;
      end else begin : gUnused
         assign nextOnZero[k] = '0;
         assign nextOnOne[k]  = '0;
      end
   end

   // From DET the search continues as if only the overlap border had been
   // matched; from a partial state it continues from the current level.
   assign fromLvl  = (phase == DET) ? RESTART_LVL : level;
   assign stepLvl  = din ? nextOnOne[fromLvl] : nextOnZero[fromLvl];
   assign legalSrc = (phase == DET) || ((phase == PART) && (level < FULL_LVL));
   assign enterDet = en && legalSrc && (stepLvl == FULL_LVL);

   // Single clocked process: reset, the saturating detection counter with
   // its clear, and the state walk. match and level are written here as
   // registers so they always reflect the state just entered. A corrupted
   // phase or an out-of-range partial level drops back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= IDLE;
         level     <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
      end else begin
         if (clr) begin
            match_cnt <= '0;
         end else if (enterDet && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
         end

         case (phase)
            IDLE: begin
               phase <= PART;
               level <= '0;
               match <= 1'b0;
            end
            PART, DET: begin
               if (!legalSrc) begin
                  phase <= IDLE;
                  level <= '0;
                  match <= 1'b0;
               end else if (en) begin
                  if (enterDet) begin
                     phase <= DET;
                     level <= FULL_LVL;
                     match <= 1'b1;
                  end else begin
                     phase <= PART;
                     level <= stepLvl;
                     match <= 1'b0;
                  end
               end
            end
            default: begin
               phase <= IDLE;
               level <= '0;
               match <= 1'b0;
            end
         endcase
      end
   end

endmodule
